// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared write-back types and sizing for the register file write port.
package regfile_wb_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int IDX_W = $clog2(NREGS);

  // Write-back request as produced by the ALU and the load/store unit
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0]  data;
  } wb_req_t;

  // Round-robin preference: which requester wins the next conflict
  typedef enum logic {
    PTR_ALU = 1'b0,
    PTR_LSU = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Grants are combinational from the
// requests and the pointer; the pointer only moves after a conflict, so a
// lone requester never steals the other side's turn.
module regfile_wb_arbiter_rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req0,   // ALU side
  input  logic i_req1,   // LSU side
  output logic o_gnt0,
  output logic o_gnt1
);

  rr_ptr_e r_ptr;
  logic    w_conflict;

  assign w_conflict = i_req0 & i_req1;
  assign o_gnt0     = i_req0 & (~i_req1 | (r_ptr == PTR_ALU));
  assign o_gnt1     = i_req1 & (~i_req0 | (r_ptr == PTR_LSU));

  // Hand preference to the loser after every contested cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= PTR_ALU;
    end else if (w_conflict) begin
      r_ptr <= (r_ptr == PTR_ALU) ? PTR_LSU : PTR_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and scoreboard: shares the single register file write
// port between ALU and LSU and tracks registers with writes in flight.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_alu_valid,
  input  logic [IDX_W-1:0] i_alu_idx,
  input  logic [XLEN-1:0]  i_alu_data,
  output logic             o_alu_ready,
  input  logic             i_lsu_valid,
  input  logic [IDX_W-1:0] i_lsu_idx,
  input  logic [XLEN-1:0]  i_lsu_data,
  output logic             o_lsu_ready,
  output logic             o_wb_we,
  output logic [IDX_W-1:0] o_wb_idx,
  output logic [XLEN-1:0]  o_wb_data,
  input  logic             i_iss_valid,
  input  logic [IDX_W-1:0] i_iss_rd,
  input  logic [IDX_W-1:0] i_q_rs1,
  input  logic [IDX_W-1:0] i_q_rs2,
  input  logic [IDX_W-1:0] i_q_rd,
  input  logic             i_q_use_rs1,
  input  logic             i_q_use_rs2,
  input  logic             i_q_use_rd,
  output logic             o_stall,
  output logic [NREGS-1:0] o_busy
);

  wb_req_t          w_alu_req;
  wb_req_t          w_lsu_req;
  wb_req_t          w_sel_req;
  logic             w_alu_gnt;
  logic             w_lsu_gnt;
  logic             w_accept;
  logic [NREGS-1:0] w_busy;

  logic             r_wb_we;
  logic [IDX_W-1:0] r_wb_idx;
  logic [XLEN-1:0]  r_wb_data;
  // Register 0 is hardwired to zero, so it never gets a busy flop
  logic [NREGS-1:1] r_busy;

  assign w_alu_req = '{valid: i_alu_valid, idx: i_alu_idx, data: i_alu_data};
  assign w_lsu_req = '{valid: i_lsu_valid, idx: i_lsu_idx, data: i_lsu_data};

  regfile_wb_arbiter_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req0 (w_alu_req.valid),
    .i_req1 (w_lsu_req.valid),
    .o_gnt0 (w_alu_gnt),
    .o_gnt1 (w_lsu_gnt)
  );

  assign o_alu_ready = w_alu_gnt;
  assign o_lsu_ready = w_lsu_gnt;
  assign w_accept    = w_alu_gnt | w_lsu_gnt;
  assign w_sel_req   = w_lsu_gnt ? w_lsu_req : w_alu_req;

  // Output register: capture the accepted request; writes to x0 are
  // accepted and recorded but never raise the write enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_we   <= 1'b0;
      r_wb_idx  <= '0;
      r_wb_data <= '0;
    end else if (w_accept) begin
      r_wb_we   <= (w_sel_req.idx != '0);
      r_wb_idx  <= w_sel_req.idx;
      r_wb_data <= w_sel_req.data;
    end else begin
      r_wb_we   <= 1'b0;
    end
  end

  assign o_wb_we   = r_wb_we;
  assign o_wb_idx  = r_wb_idx;
  assign o_wb_data = r_wb_data;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_busy
      logic w_set;
      logic w_clr;
      assign w_set = i_iss_valid & (i_iss_rd == IDX_W'(gi));
      assign w_clr = w_accept & (w_sel_req.idx == IDX_W'(gi));
      // Issue marks the register busy; an accepted write-back clears it,
      // with a same-cycle issue taking priority over the clear
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_busy[gi] <= 1'b0;
        end else if (w_set) begin
          r_busy[gi] <= 1'b1;
        end else if (w_clr) begin
          r_busy[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign w_busy = {r_busy, 1'b0};
  assign o_busy = w_busy;

  // RAW on either source or WAW on the destination holds the waiting instruction
  assign o_stall = (i_q_use_rs1 & w_busy[i_q_rs1]) |
                   (i_q_use_rs2 & w_busy[i_q_rs2]) |
                   (i_q_use_rd  & w_busy[i_q_rd]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the write-back arbiter and scoreboard.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             alu_valid, lsu_valid;
  logic [IDX_W-1:0] alu_idx, lsu_idx;
  logic [XLEN-1:0]  alu_data, lsu_data;
  logic             alu_ready, lsu_ready;
  logic             wb_we;
  logic [IDX_W-1:0] wb_idx;
  logic [XLEN-1:0]  wb_data;
  logic             iss_valid;
  logic [IDX_W-1:0] iss_rd;
  logic [IDX_W-1:0] q_rs1, q_rs2, q_rd;
  logic             q_use_rs1, q_use_rs2, q_use_rd;
  logic             stall;
  logic [NREGS-1:0] busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_alu_valid (alu_valid),
    .i_alu_idx   (alu_idx),
    .i_alu_data  (alu_data),
    .o_alu_ready (alu_ready),
    .i_lsu_valid (lsu_valid),
    .i_lsu_idx   (lsu_idx),
    .i_lsu_data  (lsu_data),
    .o_lsu_ready (lsu_ready),
    .o_wb_we     (wb_we),
    .o_wb_idx    (wb_idx),
    .o_wb_data   (wb_data),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .i_q_rs1     (q_rs1),
    .i_q_rs2     (q_rs2),
    .i_q_rd      (q_rd),
    .i_q_use_rs1 (q_use_rs1),
    .i_q_use_rs2 (q_use_rs2),
    .i_q_use_rd  (q_use_rd),
    .o_stall     (stall),
    .o_busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [IDX_W-1:0] ai, input logic [XLEN-1:0] ad,
                       input logic lv, input logic [IDX_W-1:0] li, input logic [XLEN-1:0] ld);
    alu_valid = av; alu_idx = ai; alu_data = ad;
    lsu_valid = lv; lsu_idx = li; lsu_data = ld;
  endtask

  // Conflict window: ALU data changes only after its own accept
  logic [XLEN-1:0] rr_alu_d [4];
  logic [XLEN-1:0] rr_lsu_d [4];
  logic [XLEN-1:0] rr_exp_d [4];
  logic [IDX_W-1:0] rr_exp_i [4];

  initial begin
    rr_alu_d = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0001, 32'hA000_0002};
    rr_lsu_d = '{32'hB000_0000, 32'hB000_0000, 32'hB000_0001, 32'hB000_0001};
    rr_exp_d = '{32'hA000_0000, 32'hB000_0000, 32'hA000_0001, 32'hB000_0001};
    rr_exp_i = '{5'd1, 5'd2, 5'd1, 5'd2};

    // Reset with both requesters asserting valid
    rst = 1'b1;
    drive(1'b1, 5'd4, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222);
    iss_valid = 1'b0; iss_rd = '0;
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;
    q_use_rs1 = 1'b0; q_use_rs2 = 1'b0; q_use_rd = 1'b0;
    tick(); tick(); tick();
    $display("step reset: valids held high during reset");
    chk("reset_wb_we", 64'(wb_we), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_wb_idx", 64'(wb_idx), 64'd0);
    chk("reset_wb_data", 64'(wb_data), 64'd0);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #2 rst = 1'b0;

    // First request after release: ALU only
    tick();
    drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, '0, '0);
    #1;
    chk("first_alu_ready", 64'(alu_ready), 64'd1);
    chk("first_lsu_ready", 64'(lsu_ready), 64'd0);
    tick();
    $display("step first write: idx=3 data=deadbeef");
    chk("first_wb_we", 64'(wb_we), 64'd1);
    chk("first_wb_idx", 64'(wb_idx), 64'd3);
    chk("first_wb_data", 64'(wb_data), 64'hDEAD_BEEF);

    // Both valid for four cycles: grants alternate starting with ALU
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'd1, rr_alu_d[k], 1'b1, 5'd2, rr_lsu_d[k]);
      #1;
      chk($sformatf("rr%0d_alu_ready", k), 64'(alu_ready), 64'((k % 2) == 0));
      chk($sformatf("rr%0d_lsu_ready", k), 64'(lsu_ready), 64'((k % 2) == 1));
      tick();
      $display("step rr%0d: wb idx=%0d data=%h", k, wb_idx, wb_data);
      chk($sformatf("rr%0d_wb_we", k), 64'(wb_we), 64'd1);
      chk($sformatf("rr%0d_wb_idx", k), 64'(wb_idx), 64'(rr_exp_i[k]));
      chk($sformatf("rr%0d_wb_data", k), 64'(wb_data), 64'(rr_exp_d[k]));
    end

    // Write to x0 plus an issue targeting x0
    drive(1'b1, 5'd0, 32'h0000_1234, 1'b0, '0, '0);
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    chk("x0_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    iss_valid = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    $display("step x0 write: we=%0d idx=%0d data=%h", wb_we, wb_idx, wb_data);
    chk("x0_wb_we", 64'(wb_we), 64'd0);
    chk("x0_wb_idx", 64'(wb_idx), 64'd0);
    chk("x0_wb_data", 64'(wb_data), 64'h1234);
    chk("x0_busy", 64'(busy), 64'd0);

    // No accept: wb_idx/wb_data hold
    tick();
    chk("idle_wb_we", 64'(wb_we), 64'd0);
    chk("idle_wb_data_hold", 64'(wb_data), 64'h1234);

    // RAW hazard on x5 until the load writes it back
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0;
    q_rs1 = 5'd5; q_use_rs1 = 1'b1;
    #1;
    $display("step issue rd=5: busy=%h stall=%0d", busy, stall);
    chk("raw_busy5", 64'(busy), 64'h20);
    chk("raw_stall", 64'(stall), 64'd1);
    q_use_rs1 = 1'b0;
    #1;
    chk("raw_unused_nostall", 64'(stall), 64'd0);
    q_use_rs1 = 1'b1;
    tick();
    chk("raw_stall_hold", 64'(stall), 64'd1);
    drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h0000_0055);
    #1;
    chk("raw_lsu_ready", 64'(lsu_ready), 64'd1);
    chk("raw_stall_accept_cycle", 64'(stall), 64'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    $display("step load idx=5: wb_we=%0d busy=%h stall=%0d", wb_we, busy, stall);
    chk("raw_stall_released", 64'(stall), 64'd0);
    chk("raw_busy_clear", 64'(busy), 64'd0);
    chk("raw_wb_idx", 64'(wb_idx), 64'd5);
    q_use_rs1 = 1'b0; q_rs1 = '0;

    // Set and clear of x7 in the same cycle: set wins
    iss_valid = 1'b1; iss_rd = 5'd7;
    drive(1'b1, 5'd7, 32'h0000_0077, 1'b0, '0, '0);
    tick();
    iss_valid = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    q_rd = 5'd7; q_use_rd = 1'b1;
    #1;
    $display("step set/clear x7: busy=%h stall=%0d", busy, stall);
    chk("waw_busy7", 64'(busy), 64'h80);
    chk("waw_stall", 64'(stall), 64'd1);
    chk("waw_wb_idx", 64'(wb_idx), 64'd7);
    q_use_rd = 1'b0; q_rd = '0;
    // Retire the in-flight x7 write
    drive(1'b1, 5'd7, 32'h0000_0777, 1'b0, '0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    chk("waw_busy_retired", 64'(busy), 64'd0);

    // Contested grant goes to ALU, moving the pointer to LSU
    drive(1'b1, 5'd1, 32'h0000_0101, 1'b1, 5'd2, 32'h0000_0202);
    #1;
    chk("pre_rst_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    // Write to x9 in flight while x11 is marked busy
    drive(1'b1, 5'd9, 32'h0000_0099, 1'b0, '0, '0);
    iss_valid = 1'b1; iss_rd = 5'd11;
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    iss_valid = 1'b0;
    chk("pre_rst_wb_we", 64'(wb_we), 64'd1);
    chk("pre_rst_wb_idx", 64'(wb_idx), 64'd9);
    chk("pre_rst_busy", 64'(busy), 64'h800);
    #2 rst = 1'b1;
    #1;
    $display("step async reset: wb_we=%0d busy=%h", wb_we, busy);
    chk("async_rst_wb_we", 64'(wb_we), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_rst%0d_wb_we", k), 64'(wb_we), 64'd0);
    end
    // Pointer returned to ALU-preferred
    drive(1'b1, 5'd1, 32'h0000_0111, 1'b1, 5'd2, 32'h0000_0222);
    #1;
    $display("step post-reset conflict: alu_ready=%0d lsu_ready=%0d", alu_ready, lsu_ready);
    chk("post_rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("post_rst_lsu_ready", 64'(lsu_ready), 64'd0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    chk("post_rst_wb_data", 64'(wb_data), 64'h111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
